fp_pack: RTL and testbench
==========================

Name: fp_pack

Overview:
- Output-side counterpart of the operand unpacker.
- Takes a result in the internal 65-bit extended format: sign, 12-bit exponent with bias 2047, 52-bit fraction with the hidden bit implied.
- Rounds it, denormalizes it where needed, and packs it to IEEE single or double with RISC-V flags.
- Multi-cycle: a valid/ready FSM with a 1-bit-per-cycle denormalization shifter. Sits between the FPU datapath and the register-file writeback.

Parameters:
- none

Ports:
- clock      in   1   rising-edge clock
- reset      in   1   asynchronous, active-low reset
- in_valid   in   1   input transaction valid
- in_ready   out  1   block can accept; equals (state==IDLE)
- in_data    in   65  [64] sign, [63:52] exp (bias 2047), [51:0] fraction
- in_grs     in   2   [1] round bit, [0] sticky bit below in_data[0]
- in_fmt     in   2   0 = single, 1 = double, 2/3 = reserved
- in_rm      in   3   0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
- out_valid  out  1   result valid
- out_ready  in   1   consumer accepts result
- out_data   out  64  packed result; single is NaN-boxed (bits [63:32] all ones)
- out_flags  out  5   {NV,DZ,OF,UF,NX}; NV and DZ are always 0

Behaviour:
- Reset state: IDLE; out_valid=0, out_data=0, out_flags=0; in_ready=1 while reset is held.
- FSM states: IDLE -> (SHIFT) -> ROUND -> HOLD -> IDLE.
- IDLE:
  - Capture on in_valid & in_ready.
  - Per format: B=127/1023, emax=254/2046, F=23/52.
  - Single: sig={1,in_data[51:29]}, r=in_data[28], s=|in_data[27:0] | in_grs[1] | in_grs[0].
  - Double: sig={1,in_data[51:0]}, r=in_grs[1], s=in_grs[0].
  - e = E - 2047 + B, 13-bit signed.
- Classification at capture:
  - E=12'hFFF with fraction 0 -> infinity.
  - E=12'hFFF with fraction nonzero -> canonical NaN: 0x7FC00000 or 0x7FF8000000000000, sign dropped, flags 0.
  - E=0 with fraction 0 -> signed zero.
  - Specials go straight to ROUND with rounding bypassed.
  - e>=1 -> ROUND.
  - e<1 -> tiny=1, cnt=min(1-e, F+2), then SHIFT; if cnt would be 0 go to ROUND.
- SHIFT, one cycle per bit:
  - s |= r, r = sig[0], sig >>= 1, cnt--.
  - Leave for ROUND when cnt reaches 0. The exponent field is then 0.
- ROUND:
  - inexact = r|s.
  - inc: RNE = r&(s|sig[0]); RTZ = 0; RDN = sign&inexact; RUP = ~sign&inexact; RMM = r.
  - sig+inc carry out of the hidden position -> exponent+1, fraction=0. For tiny results, a carry into the hidden bit yields biased exponent 1.
  - Overflow when the biased exponent exceeds emax:
    - Set OF and NX.
    - Result is infinity for RNE/RMM, for RUP with +, and for RDN with -.
    - Otherwise the result is max finite: 0x7F7FFFFF / 0x7FEFFFFFFFFFFFFF with sign.
  - NX = inexact | OF.
  - UF = tiny & inexact; tininess is detected before rounding.
  - Register out_data and out_flags, then go to HOLD.
- HOLD:
  - out_valid=1; out_data and out_flags stay stable until out_ready.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - There is no overlap between transactions.
- Latency, counting the accept edge as cycle 0: out_valid rises at cycle 2 for normal and special inputs, and at cycle 2+cnt for tiny inputs.
- in_fmt 2/3: out_data=0, flags=0, normal latency.
- Reset asserted in any state, including mid-SHIFT or HOLD: immediate return to reset values; the pending result is discarded.
- in_valid while not in IDLE is ignored; no capture occurs.

Test Plan:
- Single 1.0: in_data={0,12'h7FF,0}, fmt0, rm0 -> out_data 0xFFFFFFFF3F800000, flags 0x00, out_valid at cycle 2.
- Double RNE ties:
  - E=0x7FF, fraction 0, grs=2'b10 -> 0x3FF0000000000000, flags 0x01.
  - Same with fraction LSB=1 -> 0x3FF0000000000002, flags 0x01.
- Single tiny, E=0x77F, fraction 0:
  - Exact: 0xFFFFFFFF00200000, flags 0, out_valid at cycle 4.
  - With grs=2'b01: same data, flags 0x03 (UF|NX).
- Double overflow, E=0xBFF:
  - RNE -> 0x7FF0000000000000, flags 0x05.
  - RTZ -> 0x7FEFFFFFFFFFFFFF, flags 0x05.
  - Sign=1 with RUP -> 0xFFEFFFFFFFFFFFFF.
- Specials:
  - E=0xFFF, fraction nonzero, fmt0 -> 0xFFFFFFFF7FC00000, flags 0.
  - E=0xFFF, fraction 0, sign 1, fmt1 -> 0xFFF0000000000000.
  - E=0, fraction 0, sign 1, fmt1 -> 0x8000000000000000.
- Handshake and reset:
  - out_ready=0 for 5 cycles -> out_data stable, in_ready=0, a second in_valid is not captured.
  - reset pulse during SHIFT -> out_valid=0, in_ready=1, next transaction correct.

Source files
------------

// File: rtl/fp_pack.sv
// fp_pack: takes a 65-bit extended-format result, then rounds, denormalizes and packs it to
// IEEE single (NaN-boxed) or double with RISC-V exception flags. A multi-cycle valid/ready
// FSM denormalizes one bit per cycle.
module fp_pack (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [64:0] in_data,
  input  logic [1:0]  in_grs,
  input  logic [1:0]  in_fmt,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_flags
);

  typedef enum logic [1:0] {StIdle, StShift, StRound, StHold} state_e;
  typedef enum logic [2:0] {KNum, KInf, KNan, KZero, KRsvd} kind_e;

  state_e             state_q;
  kind_e              kind_q;
  logic               sign_q;
  logic               dbl_q;
  logic [2:0]         rm_q;
  logic [52:0]        sig_q;
  logic               r_q;
  logic               s_q;
  logic signed [12:0] exp_q;
  logic [5:0]         cnt_q;
  logic               tiny_q;

  assign in_ready = (state_q == StIdle);

  // Capture-side decode: rebias the exponent, pick the significand, classify specials.
  logic               cap_dbl;
  logic               cap_frac_nz;
  logic signed [12:0] cap_exp;
  logic [13:0]        cap_need;
  logic [5:0]         cap_lim;
  logic [5:0]         cap_cnt;
  logic [52:0]        cap_sig;
  logic               cap_r;
  logic               cap_s;
  kind_e              cap_kind;

  always_comb begin
    cap_dbl     = (in_fmt == 2'd1);
    cap_frac_nz = |in_data[51:0];
    cap_exp     = $signed({1'b0, in_data[63:52]}) - 13'sd2047
                  + (cap_dbl ? 13'sd1023 : 13'sd127);
    // Only meaningful when cap_exp < 1, where it is a small positive shift count.
    cap_need    = 14'd1 - {cap_exp[12], cap_exp};
    cap_lim     = cap_dbl ? 6'd54 : 6'd25;
    cap_cnt     = (cap_need > {8'd0, cap_lim}) ? cap_lim : cap_need[5:0];
    if (cap_dbl) begin
      cap_sig = {1'b1, in_data[51:0]};
      cap_r   = in_grs[1];
      cap_s   = in_grs[0];
    end else begin
      cap_sig = {29'd0, 1'b1, in_data[51:29]};
      cap_r   = in_data[28];
      cap_s   = (|in_data[27:0]) | (|in_grs);
    end
    if (in_fmt[1]) begin
      cap_kind = KRsvd;
    end else if (in_data[63:52] == 12'hFFF) begin
      cap_kind = cap_frac_nz ? KNan : KInf;
    end else if ((in_data[63:52] == 12'h000) && !cap_frac_nz) begin
      cap_kind = KZero;
    end else begin
      cap_kind = KNum;
    end
  end

  // Rounding and packing of the captured (possibly denormalized) value.
  logic               inexact;
  logic               inc;
  logic [53:0]        sum;
  logic               hid;
  logic               carry;
  logic signed [12:0] exp_out;
  logic               ovf;
  logic               ovf_inf;
  logic [63:0]        rnd_data;
  logic [4:0]         rnd_flags;

  always_comb begin
    inexact = r_q | s_q;
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & inexact;
      3'd3:    inc = ~sign_q & inexact;
      3'd4:    inc = r_q;
      default: inc = r_q & (s_q | sig_q[0]);
    endcase
    sum   = {1'b0, sig_q} + {53'd0, inc};
    hid   = dbl_q ? sum[52] : sum[23];
    carry = dbl_q ? sum[53] : sum[24];
    // Tiny values carry exponent 0; rounding into the hidden bit makes them normal (exp 1).
    // Otherwise a carry past the hidden bit bumps the exponent; the fraction bits are 0 then.
    exp_out = exp_q + $signed({12'd0, tiny_q ? hid : carry});
    ovf     = exp_out > (dbl_q ? 13'sd2046 : 13'sd254);
    case (rm_q)
      3'd1:    ovf_inf = 1'b0;
      3'd2:    ovf_inf = sign_q;
      3'd3:    ovf_inf = ~sign_q;
      default: ovf_inf = 1'b1;
    endcase
    rnd_data  = 64'd0;
    rnd_flags = 5'd0;
    case (kind_q)
      KNum: begin
        rnd_flags = {2'b00, ovf, tiny_q & inexact, inexact | ovf};
        if (dbl_q) begin
          if (ovf) rnd_data = ovf_inf ? {sign_q, 11'h7FF, 52'd0} : {sign_q, 11'h7FE, {52{1'b1}}};
          else     rnd_data = {sign_q, exp_out[10:0], sum[51:0]};
        end else begin
          if (ovf) rnd_data = ovf_inf ? {32'hFFFF_FFFF, sign_q, 8'hFF, 23'd0}
                                      : {32'hFFFF_FFFF, sign_q, 8'hFE, {23{1'b1}}};
          else     rnd_data = {32'hFFFF_FFFF, sign_q, exp_out[7:0], sum[22:0]};
        end
      end
      KInf:  rnd_data = dbl_q ? {sign_q, 11'h7FF, 52'd0} : {32'hFFFF_FFFF, sign_q, 8'hFF, 23'd0};
      KNan:  rnd_data = dbl_q ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
      KZero: rnd_data = dbl_q ? {sign_q, 63'd0} : {32'hFFFF_FFFF, sign_q, 31'd0};
      default: ;
    endcase
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      kind_q    <= KNum;
      sign_q    <= 1'b0;
      dbl_q     <= 1'b0;
      rm_q      <= 3'd0;
      sig_q     <= 53'd0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      exp_q     <= 13'sd0;
      cnt_q     <= 6'd0;
      tiny_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
      out_flags <= 5'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q  <= in_data[64];
            dbl_q   <= cap_dbl;
            rm_q    <= in_rm;
            kind_q  <= cap_kind;
            sig_q   <= cap_sig;
            r_q     <= cap_r;
            s_q     <= cap_s;
            exp_q   <= cap_exp;
            tiny_q  <= 1'b0;
            cnt_q   <= 6'd0;
            state_q <= StRound;
            if ((cap_kind == KNum) && (cap_exp < 13'sd1)) begin
              tiny_q <= 1'b1;
              exp_q  <= 13'sd0;
              cnt_q  <= cap_cnt;
              if (cap_cnt != 6'd0) state_q <= StShift;
            end
          end
        end
        StShift: begin
          s_q   <= s_q | r_q;
          r_q   <= sig_q[0];
          sig_q <= {1'b0, sig_q[52:1]};
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_q <= StRound;
        end
        StRound: begin
          out_data  <= rnd_data;
          out_flags <= rnd_flags;
          out_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_pack.sv
// Testbench for fp_pack: directed vectors, randomized transactions against a value-level
// reference model, back-pressure and asynchronous reset during denormalization.
module tb_fp_pack;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_data;
  logic [1:0]  in_grs;
  logic [1:0]  in_fmt;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_flags;

  int checks = 0;
  int errors = 0;

  fp_pack dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_grs    (in_grs),
    .in_fmt    (in_fmt),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [64:0] d;
    logic [1:0]  g;
    logic [1:0]  f;
    logic [2:0]  rm;
    logic [63:0] ed;
    logic [4:0]  ef;
    int          el;
    string       nm;
  } vec_t;

  // Reference: align the whole significand once, take round/sticky, round, then pack.
  function automatic void model(input logic [64:0] d, input logic [1:0] g, input logic [1:0] f,
                                input logic [2:0] rm, output logic [63:0] od,
                                output logic [4:0] of, output int lat);
    int fb, bias, emax, big_e, e, sh, shift, ex;
    logic [127:0] x, mask;
    logic [63:0] kept, m, fr;
    logic neg, rnd, st, inexact, inc, tiny, ovf, to_inf;
    neg = d[64];
    lat = 2;
    of  = 5'd0;
    od  = 64'd0;
    if (f[1]) return;
    fb    = f[0] ? 52 : 23;
    bias  = f[0] ? 1023 : 127;
    emax  = f[0] ? 2046 : 254;
    big_e = int'(d[63:52]);
    if (big_e == 4095) begin
      if (d[51:0] != 0) od = f[0] ? 64'h7FF8000000000000 : 64'hFFFFFFFF7FC00000;
      else od = f[0] ? {neg, 11'h7FF, 52'd0} : {32'hFFFFFFFF, neg, 8'hFF, 23'd0};
      return;
    end
    if (big_e == 0 && d[51:0] == 0) begin
      od = f[0] ? {neg, 63'd0} : {32'hFFFFFFFF, neg, 31'd0};
      return;
    end
    e     = big_e - 2047 + bias;
    tiny  = (e < 1);
    sh    = tiny ? (((1 - e) < fb + 2) ? (1 - e) : fb + 2) : 0;
    lat   = 2 + sh;
    x     = {73'd0, 1'b1, d[51:0], g};
    shift = 54 - fb + sh;
    kept  = 64'(x >> shift);
    rnd   = x[shift-1];
    mask  = (128'd1 << (shift - 1)) - 128'd1;
    st    = (x & mask) != 0;
    inexact = rnd | st;
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = neg & inexact;
      3'd3:    inc = !neg & inexact;
      3'd4:    inc = rnd;
      default: inc = rnd & (st | kept[0]);
    endcase
    m = kept + 64'(inc);
    if (tiny) ex = ((m >> fb) != 0) ? 1 : 0;
    else if ((m >> (fb + 1)) != 0) begin ex = e + 1; m = m >> 1; end
    else ex = e;
    ovf = (ex > emax);
    of  = {2'b00, ovf, tiny & inexact, inexact | ovf};
    fr  = m & ((64'd1 << fb) - 64'd1);
    if (ovf) begin
      to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? neg : (rm == 3'd3) ? !neg : 1'b1;
      if (f[0]) od = to_inf ? {neg, 11'h7FF, 52'd0} : {neg, 11'h7FE, {52{1'b1}}};
      else od = to_inf ? {32'hFFFFFFFF, neg, 8'hFF, 23'd0}
                       : {32'hFFFFFFFF, neg, 8'hFE, {23{1'b1}}};
    end else begin
      if (f[0]) od = {neg, 11'(ex), fr[51:0]};
      else od = {32'hFFFFFFFF, neg, 8'(ex), fr[22:0]};
    end
  endfunction

  // Drives one transaction from a negedge with out_ready high; lat counts cycles after accept.
  task automatic run_txn(input logic [64:0] d, input logic [1:0] g, input logic [1:0] f,
                         input logic [2:0] rm, output logic [63:0] od, output logic [4:0] of,
                         output int lat);
    in_data   = d;
    in_grs    = g;
    in_fmt    = f;
    in_rm     = rm;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    od = out_data;
    of = out_flags;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_flags !== 5'd0) begin errors++; $display("FAIL reset_out_flags: got %h expected 0", out_flags); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [63:0] od;
    logic [4:0] of;
    int lat;
    v.push_back('{{1'b0, 12'h7FF, 52'd0}, 2'b00, 2'd0, 3'd0, 64'hFFFFFFFF3F800000, 5'h00, 2, "single_one"});
    v.push_back('{{1'b0, 12'h7FF, 52'd0}, 2'b10, 2'd1, 3'd0, 64'h3FF0000000000000, 5'h01, 2, "dbl_tie_even"});
    v.push_back('{{1'b0, 12'h7FF, 52'd1}, 2'b10, 2'd1, 3'd0, 64'h3FF0000000000002, 5'h01, 2, "dbl_tie_odd"});
    v.push_back('{{1'b0, 12'h77F, 52'd0}, 2'b00, 2'd0, 3'd0, 64'hFFFFFFFF00200000, 5'h00, 4, "single_tiny_exact"});
    v.push_back('{{1'b0, 12'h77F, 52'd0}, 2'b01, 2'd0, 3'd0, 64'hFFFFFFFF00200000, 5'h03, 4, "single_tiny_inexact"});
    v.push_back('{{1'b0, 12'h780, 52'hFFFFFE0000000}, 2'b00, 2'd0, 3'd3, 64'hFFFFFFFF00800000, 5'h03, 3, "single_tiny_carry"});
    v.push_back('{{1'b0, 12'hBFF, 52'd0}, 2'b00, 2'd1, 3'd0, 64'h7FF0000000000000, 5'h05, 2, "dbl_ovf_rne"});
    v.push_back('{{1'b0, 12'hBFF, 52'd0}, 2'b00, 2'd1, 3'd1, 64'h7FEFFFFFFFFFFFFF, 5'h05, 2, "dbl_ovf_rtz"});
    v.push_back('{{1'b1, 12'hBFF, 52'd0}, 2'b00, 2'd1, 3'd3, 64'hFFEFFFFFFFFFFFFF, 5'h05, 2, "dbl_ovf_rup_neg"});
    v.push_back('{{1'b1, 12'hFFF, 52'd5}, 2'b00, 2'd0, 3'd0, 64'hFFFFFFFF7FC00000, 5'h00, 2, "single_nan"});
    v.push_back('{{1'b1, 12'hFFF, 52'd0}, 2'b00, 2'd1, 3'd0, 64'hFFF0000000000000, 5'h00, 2, "dbl_neg_inf"});
    v.push_back('{{1'b1, 12'h000, 52'd0}, 2'b00, 2'd1, 3'd0, 64'h8000000000000000, 5'h00, 2, "dbl_neg_zero"});
    v.push_back('{{1'b0, 12'h3FF, 52'h12345}, 2'b11, 2'd2, 3'd0, 64'h0000000000000000, 5'h00, 2, "fmt_reserved"});
    foreach (v[i]) begin
      run_txn(v[i].d, v[i].g, v[i].f, v[i].rm, od, of, lat);
      checks++; if (od !== v[i].ed) begin errors++; $display("FAIL %s data: got %h expected %h", v[i].nm, od, v[i].ed); end
      checks++; if (of !== v[i].ef) begin errors++; $display("FAIL %s flags: got %h expected %h", v[i].nm, of, v[i].ef); end
      checks++; if (lat != v[i].el) begin errors++; $display("FAIL %s latency: got %0d expected %0d", v[i].nm, lat, v[i].el); end
    end
  endtask

  function automatic void rand_op(output logic [64:0] d, output logic [1:0] g,
                                  output logic [1:0] f, output logic [2:0] rm);
    int c, fsel, bias, emax, fb, e;
    logic [51:0] fr;
    fsel = int'($urandom_range(0, 9));
    f    = (fsel < 5) ? 2'd0 : (fsel < 9) ? 2'd1 : 2'($urandom_range(2, 3));
    bias = f[0] ? 1023 : 127;
    emax = f[0] ? 2046 : 254;
    fb   = f[0] ? 52 : 23;
    rm   = 3'($urandom_range(0, 7));
    g    = 2'($urandom_range(0, 3));
    fr   = {20'($urandom), $urandom};
    if ($urandom_range(0, 3) == 0) fr[28:0] = 29'($urandom_range(0, 1) << 28);
    c = int'($urandom_range(0, 9));
    if (c < 5)       e = int'($urandom_range(1, emax));
    else if (c == 5) e = emax - 1 + int'($urandom_range(0, 2));
    else if (c < 8)  e = -(fb + 4) + int'($urandom_range(0, fb + 4));
    else e = -5000;
    d = {1'($urandom), 12'd0, fr};
    if (c == 8) begin
      d[63:52] = $urandom_range(0, 1) ? 12'hFFF : 12'h000;
      if ($urandom_range(0, 1)) d[51:0] = 52'd0;
    end else if (c == 9) d[63:52] = 12'($urandom);
    else d[63:52] = 12'(e + 2047 - bias);
  endfunction

  task automatic test_random();
    logic [64:0] d;
    logic [1:0] g, f;
    logic [2:0] rm;
    logic [63:0] od, ed;
    logic [4:0] of, ef;
    int lat, el;
    for (int n = 0; n < 250; n++) begin
      rand_op(d, g, f, rm);
      model(d, g, f, rm, ed, ef, el);
      run_txn(d, g, f, rm, od, of, lat);
      checks++; if (od !== ed) begin errors++; $display("FAIL rand%0d data: in %h grs %b fmt %0d rm %0d got %h expected %h", n, d, g, f, rm, od, ed); end
      checks++; if (of !== ef) begin errors++; $display("FAIL rand%0d flags: in %h grs %b fmt %0d rm %0d got %h expected %h", n, d, g, f, rm, of, ef); end
      checks++; if (lat != el) begin errors++; $display("FAIL rand%0d latency: got %0d expected %0d", n, lat, el); end
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] ed, held;
    logic [4:0] ef;
    int el, n;
    model({1'b0, 12'h800, 52'hABCDE12345678}, 2'b11, 2'd1, 3'd0, ed, ef, el);
    in_data   = {1'b0, 12'h800, 52'hABCDE12345678};
    in_grs    = 2'b11;
    in_fmt    = 2'd1;
    in_rm     = 3'd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    held = out_data;
    checks++; if (held !== ed) begin errors++; $display("FAIL bp_data: got %h expected %h", held, ed); end
    checks++; if (out_flags !== ef) begin errors++; $display("FAIL bp_flags: got %h expected %h", out_flags, ef); end
    in_data  = {1'b1, 12'h7FF, 52'd7};
    in_fmt   = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %b data %h in_ready %b expected 1 %h 0", i, out_valid, out_data, in_ready, ed);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b in_ready %b expected 0 1", out_valid, in_ready); end
    repeat (4) @(negedge clock);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_capture: valid %b in_ready %b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] od, ed;
    logic [4:0] of, ef;
    int lat, el;
    bit stray;
    in_data   = {1'b0, 12'h000, 52'h1};
    in_grs    = 2'b00;
    in_fmt    = 2'd1;
    in_rm     = 3'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL shift_busy: in_ready %b expected 0", in_ready); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_shift_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_shift_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 64'd0 || out_flags !== 5'd0) begin errors++; $display("FAIL rst_shift_out: data %h flags %h expected 0 0", out_data, out_flags); end
    @(negedge clock);
    reset = 1'b1;
    stray = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL rst_discard: stale out_valid seen, expected none"); end
    model({1'b1, 12'h7FE, 52'hFFFFFFFFFFFFF}, 2'b11, 2'd0, 3'd4, ed, ef, el);
    run_txn({1'b1, 12'h7FE, 52'hFFFFFFFFFFFFF}, 2'b11, 2'd0, 3'd4, od, of, lat);
    checks++; if (od !== ed) begin errors++; $display("FAIL post_rst_data: got %h expected %h", od, ed); end
    checks++; if (of !== ef) begin errors++; $display("FAIL post_rst_flags: got %h expected %h", of, ef); end
    checks++; if (lat != el) begin errors++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, el); end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_grs    = '0;
    in_fmt    = '0;
    in_rm     = '0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
